// File: rtl/rename_map_table.sv
// Register rename stage: speculative map + ready bits, retirement map for flush recovery.
// Renames up to N_WAY instructions per cycle using tags supplied by the free list.
module rename_map_table #(
  parameter int unsigned N_WAY    = 2,
  parameter int unsigned N_ROB    = 32,
  parameter int unsigned TAG_BITS = 7
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_WAY-1:0]              disp_valid,
  input  logic [N_WAY-1:0]              disp_rd_wr,
  input  logic [N_WAY*5-1:0]            disp_rd,
  input  logic [N_WAY*5-1:0]            disp_rs1,
  input  logic [N_WAY*5-1:0]            disp_rs2,
  input  logic [N_WAY*TAG_BITS-1:0]     fl_tag,
  input  logic [$clog2(N_WAY):0]        fl_avail,
  input  logic [N_WAY-1:0]              cdb_valid,
  input  logic [N_WAY*TAG_BITS-1:0]     cdb_tag,
  input  logic [N_WAY-1:0]              ret_valid,
  input  logic [N_WAY*5-1:0]            ret_rd,
  input  logic [N_WAY*TAG_BITS-1:0]     ret_tag,
  input  logic                          flush,
  output logic [N_WAY-1:0]              disp_accept,
  output logic [$clog2(N_WAY):0]        fl_req_num,
  output logic [N_WAY-1:0]              fl_consumed,
  output logic [N_WAY*TAG_BITS-1:0]     ren_t,
  output logic [N_WAY*TAG_BITS-1:0]     ren_told,
  output logic [N_WAY*TAG_BITS-1:0]     ren_t1,
  output logic [N_WAY*TAG_BITS-1:0]     ren_t2,
  output logic [N_WAY-1:0]              ren_t1_rdy,
  output logic [N_WAY-1:0]              ren_t2_rdy
);

  localparam int unsigned CntW    = $clog2(N_WAY) + 1;
  localparam int unsigned NumTags = N_ROB + 32;

  logic [TAG_BITS-1:0] map_q  [32];
  logic [TAG_BITS-1:0] map_d  [32];
  logic [TAG_BITS-1:0] arch_q [32];
  logic [TAG_BITS-1:0] arch_d [32];
  logic [NumTags:0]    ready_q, ready_d;

  logic [4:0]          rd_a     [N_WAY];
  logic [4:0]          rs1_a    [N_WAY];
  logic [4:0]          rs2_a    [N_WAY];
  logic [4:0]          retrd_a  [N_WAY];
  logic [TAG_BITS-1:0] fltag_a  [N_WAY];
  logic [TAG_BITS-1:0] cdbtag_a [N_WAY];
  logic [TAG_BITS-1:0] rettag_a [N_WAY];

  logic [TAG_BITS-1:0] t_a    [N_WAY];
  logic [TAG_BITS-1:0] told_a [N_WAY];
  logic [TAG_BITS-1:0] t1_a   [N_WAY];
  logic [TAG_BITS-1:0] t2_a   [N_WAY];
  logic [N_WAY-1:0]    r1_a, r2_a;

  logic [N_WAY-1:0]    writer, alloc;
  logic [CntW-1:0]     avail, wcnt;
  logic                stop;

  always_comb begin
    for (int i = 0; i < N_WAY; i++) begin
      rd_a[i]     = disp_rd[i*5 +: 5];
      rs1_a[i]    = disp_rs1[i*5 +: 5];
      rs2_a[i]    = disp_rs2[i*5 +: 5];
      retrd_a[i]  = ret_rd[i*5 +: 5];
      fltag_a[i]  = fl_tag[i*TAG_BITS +: TAG_BITS];
      cdbtag_a[i] = cdb_tag[i*TAG_BITS +: TAG_BITS];
      rettag_a[i] = ret_tag[i*TAG_BITS +: TAG_BITS];
    end
  end

  // Map-sourced readiness includes same-cycle completions so no wakeup is missed.
  function automatic logic tag_ready(input logic [TAG_BITS-1:0] tag);
    logic rdy;
    rdy = ready_q[tag];
    for (int c = 0; c < N_WAY; c++) begin
      if (cdb_valid[c] && (cdbtag_a[c] == tag)) rdy = 1'b1;
    end
    return rdy;
  endfunction

  // In-order acceptance: stop at the first invalid lane or the first writer lacking a tag.
  always_comb begin
    writer = '0;
    alloc  = '0;
    wcnt   = '0;
    stop   = flush;
    avail  = (fl_avail > CntW'(N_WAY)) ? CntW'(N_WAY) : fl_avail;
    disp_accept = '0;
    for (int i = 0; i < N_WAY; i++) begin
      t_a[i]    = '0;
      writer[i] = disp_valid[i] & disp_rd_wr[i] & (rd_a[i] != 5'd0);
      if (!disp_valid[i] || (writer[i] && (wcnt >= avail))) stop = 1'b1;
      if (!stop) begin
        disp_accept[i] = 1'b1;
        if (writer[i]) begin
          alloc[i] = 1'b1;
          for (int k = 0; k < N_WAY; k++) begin
            if (CntW'(k) == wcnt) t_a[i] = fltag_a[k];
          end
          wcnt = wcnt + CntW'(1);
        end
      end
    end
    fl_req_num = wcnt;
    for (int k = 0; k < N_WAY; k++) begin
      fl_consumed[k] = (CntW'(k) < wcnt);
    end
  end

  always_comb begin
    ren_t      = '0;
    ren_told   = '0;
    ren_t1     = '0;
    ren_t2     = '0;
    ren_t1_rdy = '0;
    ren_t2_rdy = '0;
    for (int j = 0; j < N_WAY; j++) begin
      t1_a[j]   = map_q[rs1_a[j]];
      r1_a[j]   = tag_ready(t1_a[j]);
      t2_a[j]   = map_q[rs2_a[j]];
      r2_a[j]   = tag_ready(t2_a[j]);
      told_a[j] = map_q[rd_a[j]];
      if (rs1_a[j] == 5'd0) begin
        t1_a[j] = TAG_BITS'(1);
        r1_a[j] = 1'b1;
      end
      if (rs2_a[j] == 5'd0) begin
        t2_a[j] = TAG_BITS'(1);
        r2_a[j] = 1'b1;
      end
      // Ascending scan leaves the youngest older writer in place.
      for (int i = 0; i < j; i++) begin
        if (alloc[i]) begin
          if (rd_a[i] == rs1_a[j]) begin
            t1_a[j] = t_a[i];
            r1_a[j] = 1'b0;
          end
          if (rd_a[i] == rs2_a[j]) begin
            t2_a[j] = t_a[i];
            r2_a[j] = 1'b0;
          end
          if (rd_a[i] == rd_a[j]) told_a[j] = t_a[i];
        end
      end
      if (!alloc[j]) told_a[j] = '0;
      ren_t[j*TAG_BITS +: TAG_BITS]    = t_a[j];
      ren_told[j*TAG_BITS +: TAG_BITS] = told_a[j];
      ren_t1[j*TAG_BITS +: TAG_BITS]   = t1_a[j];
      ren_t2[j*TAG_BITS +: TAG_BITS]   = t2_a[j];
      ren_t1_rdy[j]                    = r1_a[j];
      ren_t2_rdy[j]                    = r2_a[j];
    end
  end

  always_comb begin
    arch_d = arch_q;
    for (int i = 0; i < N_WAY; i++) begin
      if (ret_valid[i] && (retrd_a[i] != 5'd0)) arch_d[retrd_a[i]] = rettag_a[i];
    end
    if (flush) begin
      map_d   = arch_d;
      ready_d = '1;
    end else begin
      map_d   = map_q;
      ready_d = ready_q;
      for (int c = 0; c < N_WAY; c++) begin
        if (cdb_valid[c]) ready_d[cdbtag_a[c]] = 1'b1;
      end
      // Dispatch clears come after CDB sets so an allocation always starts unready.
      for (int i = 0; i < N_WAY; i++) begin
        if (alloc[i]) begin
          map_d[rd_a[i]]  = t_a[i];
          ready_d[t_a[i]] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        map_q[r]  <= TAG_BITS'(r + 1);
        arch_q[r] <= TAG_BITS'(r + 1);
      end
      ready_q <= '1;
    end else begin
      map_q   <= map_d;
      arch_q  <= arch_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: tb/tb_rename_map_table.sv
// Scenario bench for rename_map_table: expected outputs are queued when stimulus is driven
// and popped against the combinational outputs before the next clock edge.
module tb_rename_map_table;

  localparam int S_ACC  = 0;
  localparam int S_REQ  = 1;
  localparam int S_CONS = 2;
  localparam int S_T    = 3;
  localparam int S_TOLD = 4;
  localparam int S_T1   = 5;
  localparam int S_T2   = 6;
  localparam int S_R1   = 7;
  localparam int S_R2   = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  disp_valid, disp_rd_wr;
  logic [9:0]  disp_rd, disp_rs1, disp_rs2;
  logic [13:0] fl_tag;
  logic [1:0]  fl_avail;
  logic [1:0]  cdb_valid;
  logic [13:0] cdb_tag;
  logic [1:0]  ret_valid;
  logic [9:0]  ret_rd;
  logic [13:0] ret_tag;
  logic        flush;
  logic [1:0]  disp_accept;
  logic [1:0]  fl_req_num;
  logic [1:0]  fl_consumed;
  logic [13:0] ren_t, ren_told, ren_t1, ren_t2;
  logic [1:0]  ren_t1_rdy, ren_t2_rdy;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  rename_map_table dut (
    .clock       (clock),
    .reset       (reset),
    .disp_valid  (disp_valid),
    .disp_rd_wr  (disp_rd_wr),
    .disp_rd     (disp_rd),
    .disp_rs1    (disp_rs1),
    .disp_rs2    (disp_rs2),
    .fl_tag      (fl_tag),
    .fl_avail    (fl_avail),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .ret_valid   (ret_valid),
    .ret_rd      (ret_rd),
    .ret_tag     (ret_tag),
    .flush       (flush),
    .disp_accept (disp_accept),
    .fl_req_num  (fl_req_num),
    .fl_consumed (fl_consumed),
    .ren_t       (ren_t),
    .ren_told    (ren_told),
    .ren_t1      (ren_t1),
    .ren_t2      (ren_t2),
    .ren_t1_rdy  (ren_t1_rdy),
    .ren_t2_rdy  (ren_t2_rdy)
  );

  function automatic logic [15:0] obs(input int sel);
    case (sel)
      S_ACC:   return 16'(disp_accept);
      S_REQ:   return 16'(fl_req_num);
      S_CONS:  return 16'(fl_consumed);
      S_T:     return 16'(ren_t);
      S_TOLD:  return 16'(ren_told);
      S_T1:    return 16'(ren_t1);
      S_T2:    return 16'(ren_t2);
      S_R1:    return 16'(ren_t1_rdy);
      S_R2:    return 16'(ren_t2_rdy);
      default: return '0;
    endcase
  endfunction

  task automatic push(input string name, input int sel, input logic [15:0] exp);
    exp_t x;
    x.name = name;
    x.sel  = sel;
    x.exp  = exp;
    sb.push_back(x);
  endtask

  task automatic idle();
    disp_valid = '0; disp_rd_wr = '0;
    disp_rd = '0; disp_rs1 = '0; disp_rs2 = '0;
    fl_tag = '0; fl_avail = '0;
    cdb_valid = '0; cdb_tag = '0;
    ret_valid = '0; ret_rd = '0; ret_tag = '0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    disp_rs1 = {5'd0, 5'd5};
    push("rst_acc", S_ACC, 16'(2'b00));
    push("rst_req", S_REQ, 16'd0);
    push("rst_cons", S_CONS, 16'd0);
    push("rst_t", S_T, 16'd0);
    push("rst_told", S_TOLD, 16'd0);
    push("rst_t1", S_T1, 16'({7'd1, 7'd6}));
    push("rst_r1", S_R1, 16'(2'b11));
    push("rst_t2", S_T2, 16'({7'd1, 7'd1}));
    push("rst_r2", S_R2, 16'(2'b11));
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++;
        $display("FAIL %s got %0d expected %0d", e.name, obs(e.sel), e.exp);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_same_rd();
    idle();
    disp_valid = 2'b11; disp_rd_wr = 2'b11;
    disp_rd  = {5'd3, 5'd3};
    disp_rs1 = {5'd3, 5'd0};
    fl_tag = {7'd34, 7'd33}; fl_avail = 2'd2;
    push("same_acc", S_ACC, 16'(2'b11));
    push("same_req", S_REQ, 16'd2);
    push("same_cons", S_CONS, 16'(2'b11));
    push("same_t", S_T, 16'({7'd34, 7'd33}));
    push("same_told", S_TOLD, 16'({7'd33, 7'd4}));
    push("same_fwd_t1", S_T1, 16'({7'd33, 7'd1}));
    push("same_fwd_r1", S_R1, 16'(2'b01));
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++;
        $display("FAIL %s got %0d expected %0d", e.name, obs(e.sel), e.exp);
      end
    end
    @(negedge clock);
    idle();
    disp_rs1 = {5'd0, 5'd3};
    push("same_next_t1", S_T1, 16'({7'd1, 7'd34}));
    push("same_next_r1", S_R1, 16'(2'b10));
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++;
        $display("FAIL %s got %0d expected %0d", e.name, obs(e.sel), e.exp);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_forward();
    idle();
    disp_valid = 2'b11; disp_rd_wr = 2'b01;
    disp_rd  = {5'd0, 5'd7};
    disp_rs1 = {5'd7, 5'd7};
    fl_tag = {7'd41, 7'd40}; fl_avail = 2'd1;
    push("fwd_acc", S_ACC, 16'(2'b11));
    push("fwd_req", S_REQ, 16'd1);
    push("fwd_cons", S_CONS, 16'(2'b01));
    push("fwd_t", S_T, 16'({7'd0, 7'd40}));
    push("fwd_told", S_TOLD, 16'({7'd0, 7'd8}));
    push("fwd_t1", S_T1, 16'({7'd40, 7'd8}));
    push("fwd_r1", S_R1, 16'(2'b01));
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++;
        $display("FAIL %s got %0d expected %0d", e.name, obs(e.sel), e.exp);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_limit();
    idle();
    disp_valid = 2'b11; disp_rd_wr = 2'b11;
    disp_rd = {5'd6, 5'd5};
    fl_tag = {7'd42, 7'd41}; fl_avail = 2'd1;
    push("lim1_acc", S_ACC, 16'(2'b01));
    push("lim1_req", S_REQ, 16'd1);
    push("lim1_cons", S_CONS, 16'(2'b01));
    push("lim1_t", S_T, 16'({7'd0, 7'd41}));
    push("lim1_told", S_TOLD, 16'({7'd0, 7'd6}));
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++;
        $display("FAIL %s got %0d expected %0d", e.name, obs(e.sel), e.exp);
      end
    end
    @(negedge clock);
    // No tags: a non-writer lane 0 still goes, writer lane 1 stalls.
    idle();
    disp_valid = 2'b11; disp_rd_wr = 2'b10;
    disp_rd = {5'd6, 5'd2};
    fl_avail = 2'd0;
    push("lim0_acc", S_ACC, 16'(2'b01));
    push("lim0_req", S_REQ, 16'd0);
    push("lim0_cons", S_CONS, 16'(2'b00));
    push("lim0_t", S_T, 16'd0);
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++;
        $display("FAIL %s got %0d expected %0d", e.name, obs(e.sel), e.exp);
      end
    end
    @(negedge clock);
    // rd=x0 with rd_wr set is not a writer, so no tag is needed.
    idle();
    disp_valid = 2'b11; disp_rd_wr = 2'b11;
    fl_avail = 2'd0;
    push("x0_acc", S_ACC, 16'(2'b11));
    push("x0_req", S_REQ, 16'd0);
    push("x0_t", S_T, 16'd0);
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++;
        $display("FAIL %s got %0d expected %0d", e.name, obs(e.sel), e.exp);
      end
    end
    @(negedge clock);
    // fl_avail beyond the lane count saturates at N_WAY.
    idle();
    disp_valid = 2'b11; disp_rd_wr = 2'b11;
    disp_rd = {5'd10, 5'd9};
    fl_tag = {7'd44, 7'd43}; fl_avail = 2'd3;
    push("clamp_acc", S_ACC, 16'(2'b11));
    push("clamp_req", S_REQ, 16'd2);
    push("clamp_t", S_T, 16'({7'd44, 7'd43}));
    push("clamp_told", S_TOLD, 16'({7'd11, 7'd10}));
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++;
        $display("FAIL %s got %0d expected %0d", e.name, obs(e.sel), e.exp);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_cdb();
    idle();
    disp_rs1 = {5'd5, 5'd7};
    cdb_valid = 2'b01; cdb_tag = {7'd0, 7'd40};
    push("cdb_byp_t1", S_T1, 16'({7'd41, 7'd40}));
    push("cdb_byp_r1", S_R1, 16'(2'b01));
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++;
        $display("FAIL %s got %0d expected %0d", e.name, obs(e.sel), e.exp);
      end
    end
    @(negedge clock);
    cdb_valid = 2'b10; cdb_tag = {7'd41, 7'd0};
    push("cdb_set_r1", S_R1, 16'(2'b11));
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++;
        $display("FAIL %s got %0d expected %0d", e.name, obs(e.sel), e.exp);
      end
    end
    @(negedge clock);
    cdb_valid = 2'b00;
    push("cdb_held_r1", S_R1, 16'(2'b11));
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++;
        $display("FAIL %s got %0d expected %0d", e.name, obs(e.sel), e.exp);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_flush();
    idle();
    disp_valid = 2'b01; disp_rd_wr = 2'b01;
    disp_rd = {5'd0, 5'd3};
    fl_tag = {7'd0, 7'd35}; fl_avail = 2'd1;
    push("fl_ren_t", S_T, 16'({7'd0, 7'd35}));
    push("fl_ren_told", S_TOLD, 16'({7'd0, 7'd34}));
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++;
        $display("FAIL %s got %0d expected %0d", e.name, obs(e.sel), e.exp);
      end
    end
    @(negedge clock);
    idle();
    disp_valid = 2'b11; disp_rd_wr = 2'b11;
    disp_rd = {5'd4, 5'd3};
    disp_rs1 = {5'd0, 5'd3};
    fl_tag = {7'd37, 7'd36}; fl_avail = 2'd2;
    ret_valid = 2'b01; ret_rd = {5'd0, 5'd3}; ret_tag = {7'd0, 7'd34};
    flush = 1'b1;
    push("fl_acc", S_ACC, 16'(2'b00));
    push("fl_req", S_REQ, 16'd0);
    push("fl_cons", S_CONS, 16'(2'b00));
    push("fl_t", S_T, 16'd0);
    push("fl_told", S_TOLD, 16'd0);
    push("fl_pre_t1", S_T1, 16'({7'd1, 7'd35}));
    push("fl_pre_r1", S_R1, 16'(2'b10));
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++;
        $display("FAIL %s got %0d expected %0d", e.name, obs(e.sel), e.exp);
      end
    end
    @(negedge clock);
    idle();
    disp_rs1 = {5'd7, 5'd3};
    disp_rs2 = {5'd0, 5'd5};
    push("fl_post_t1", S_T1, 16'({7'd8, 7'd34}));
    push("fl_post_r1", S_R1, 16'(2'b11));
    push("fl_post_t2", S_T2, 16'({7'd1, 7'd6}));
    push("fl_post_r2", S_R2, 16'(2'b11));
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++;
        $display("FAIL %s got %0d expected %0d", e.name, obs(e.sel), e.exp);
      end
    end
    @(negedge clock);
    // Two retires of x3 in one cycle: the younger lane's tag must land.
    idle();
    ret_valid = 2'b11; ret_rd = {5'd3, 5'd3}; ret_tag = {7'd51, 7'd50};
    flush = 1'b1;
    @(negedge clock);
    idle();
    disp_rs1 = {5'd0, 5'd3};
    push("ret_lane_t1", S_T1, 16'({7'd1, 7'd51}));
    push("ret_lane_r1", S_R1, 16'(2'b11));
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        errors++;
        $display("FAIL %s got %0d expected %0d", e.name, obs(e.sel), e.exp);
      end
    end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_same_rd();
    test_forward();
    test_limit();
    test_cdb();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
